// File: rtl/ball_position_buffer_if.sv
// Host write / commit port plus the double-buffered ball position outputs toward the display controller.
interface ball_position_buffer_if;
   logic        iEndFrame;
   logic        iWrValid;
   logic        oWrReady;
   logic [3:0]  iWrIdx;
   logic [9:0]  iWrX;
   logic [8:0]  iWrY;
   logic        iCommit;
   logic [9:0]  oX1, oX2, oX3, oX4, oX5, oX6, oX7, oX8, oX9, oX10;
   logic [8:0]  oY1, oY2, oY3, oY4, oY5, oY6, oY7, oY8, oY9, oY10;
   logic        oCommitDone;
   logic        oOverrun;
   logic [15:0] oFrameCnt;

   modport slave (
      input  iEndFrame, iWrValid, iWrIdx, iWrX, iWrY, iCommit,
      output oWrReady,
      output oX1, oX2, oX3, oX4, oX5, oX6, oX7, oX8, oX9, oX10,
      output oY1, oY2, oY3, oY4, oY5, oY6, oY7, oY8, oY9, oY10,
      output oCommitDone, oOverrun, oFrameCnt
   );

   modport master (
      output iEndFrame, iWrValid, iWrIdx, iWrX, iWrY, iCommit,
      input  oWrReady,
      input  oX1, oX2, oX3, oX4, oX5, oX6, oX7, oX8, oX9, oX10,
      input  oY1, oY2, oY3, oY4, oY5, oY6, oY7, oY8, oY9, oY10,
      input  oCommitDone, oOverrun, oFrameCnt
   );
endinterface

// File: rtl/ball_position_buffer.sv
// Shadow/active ball position banks; a commit is copied one entry per cycle starting the cycle after the next frame end.
// Writes are held off (oWrReady=0) from commit until the copy finishes; all outputs come straight from registers.
module ball_position_buffer (
   input  logic                          iCLK,
   input  logic                          iRST_n,
   ball_position_buffer_if.slave         bus
);

   typedef struct packed {
      logic [9:0] x;
      logic [8:0] y;
   } entry_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      COPY    = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic        done_q, done_d;
   logic        overrun_q, overrun_d;
   logic [15:0] frame_cnt_q;
   entry_t      shadow_q [10];
   entry_t      active_q [10];
   logic        wr_acc;

   // Out-of-range indices are still handshaked so the host never stalls on them.
   assign wr_acc = bus.iWrValid && (state_q == IDLE) && (bus.iWrIdx <= 4'd9);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      done_d    = 1'b0;
      overrun_d = overrun_q;
      case (state_q)
         IDLE: begin
            if (bus.iCommit) state_d = PENDING;
         end
         PENDING: begin
            if (bus.iCommit) overrun_d = 1'b1;
            if (bus.iEndFrame) begin
               state_d = COPY;
               idx_d   = 4'd0;
            end
         end
         COPY: begin
            if (bus.iCommit) overrun_d = 1'b1;
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd9) begin
               state_d = IDLE;
               idx_d   = 4'd0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q   <= IDLE;
         idx_q     <= 4'd0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
      end
   end

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         frame_cnt_q <= 16'd0;
      end else if (bus.iEndFrame) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         for (int i = 0; i < 10; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         if (wr_acc) shadow_q[bus.iWrIdx] <= '{x: bus.iWrX, y: bus.iWrY};
         if (state_q == COPY) active_q[idx_q] <= shadow_q[idx_q];
      end
   end

   assign bus.oWrReady    = (state_q == IDLE);
   assign bus.oCommitDone = done_q;
   assign bus.oOverrun    = overrun_q;
   assign bus.oFrameCnt   = frame_cnt_q;

   assign bus.oX1  = active_q[0].x;  assign bus.oY1  = active_q[0].y;
   assign bus.oX2  = active_q[1].x;  assign bus.oY2  = active_q[1].y;
   assign bus.oX3  = active_q[2].x;  assign bus.oY3  = active_q[2].y;
   assign bus.oX4  = active_q[3].x;  assign bus.oY4  = active_q[3].y;
   assign bus.oX5  = active_q[4].x;  assign bus.oY5  = active_q[4].y;
   assign bus.oX6  = active_q[5].x;  assign bus.oY6  = active_q[5].y;
   assign bus.oX7  = active_q[6].x;  assign bus.oY7  = active_q[6].y;
   assign bus.oX8  = active_q[7].x;  assign bus.oY8  = active_q[7].y;
   assign bus.oX9  = active_q[8].x;  assign bus.oY9  = active_q[8].y;
   assign bus.oX10 = active_q[9].x;  assign bus.oY10 = active_q[9].y;

endmodule

// File: tb/tb_ball_position_buffer.sv
// Bench for ball_position_buffer: directed scenarios plus random traffic against a timeline-based reference model.
module tb_ball_position_buffer;

   logic iCLK;
   logic iRST_n;
   ball_position_buffer_if bus ();

   ball_position_buffer dut (
      .iCLK   (iCLK),
      .iRST_n (iRST_n),
      .bus    (bus.slave)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   int errors = 0;
   int checks = 0;

   // Reference model: banks as arrays, commit tracked as "pending" and "copy started at edge T".
   logic [9:0]  m_sx [10];
   logic [8:0]  m_sy [10];
   logic [9:0]  m_ax [10];
   logic [8:0]  m_ay [10];
   bit          m_pending, m_copying, m_overrun, m_done;
   int          m_copy_t, edge_no;
   logic [15:0] m_fcnt;

   function automatic bit m_ready();
      return !(m_pending || m_copying);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 10; k++) begin
         m_sx[k] = '0; m_sy[k] = '0; m_ax[k] = '0; m_ay[k] = '0;
      end
      m_pending = 0; m_copying = 0; m_overrun = 0; m_done = 0;
      m_fcnt = '0;
   endtask

   task automatic model_edge();
      int k;
      edge_no++;
      m_done = 0;
      if (bus.iEndFrame) m_fcnt = m_fcnt + 16'd1;
      if (m_copying) begin
         k = edge_no - m_copy_t - 1;
         m_ax[k] = m_sx[k];
         m_ay[k] = m_sy[k];
         if (k == 9) begin
            m_copying = 0;
            m_done = 1;
         end
         if (bus.iCommit) m_overrun = 1;
      end else if (m_pending) begin
         if (bus.iCommit) m_overrun = 1;
         if (bus.iEndFrame) begin
            m_pending = 0;
            m_copying = 1;
            m_copy_t = edge_no;
         end
      end else begin
         if (bus.iWrValid && bus.iWrIdx <= 4'd9) begin
            m_sx[bus.iWrIdx] = bus.iWrX;
            m_sy[bus.iWrIdx] = bus.iWrY;
         end
         if (bus.iCommit) m_pending = 1;
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge iCLK);
      #1;
   endtask

   task automatic clear_inputs();
      bus.iEndFrame = 0; bus.iWrValid = 0; bus.iWrIdx = '0;
      bus.iWrX = '0; bus.iWrY = '0; bus.iCommit = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      iRST_n = 0;
      #12;
      model_reset();
      iRST_n = 1;
      tick();
   endtask

   function automatic logic [9:0] dut_x(input int k);
      case (k)
         0: dut_x = bus.oX1;  1: dut_x = bus.oX2;  2: dut_x = bus.oX3;  3: dut_x = bus.oX4;
         4: dut_x = bus.oX5;  5: dut_x = bus.oX6;  6: dut_x = bus.oX7;  7: dut_x = bus.oX8;
         8: dut_x = bus.oX9;  9: dut_x = bus.oX10; default: dut_x = '0;
      endcase
   endfunction

   function automatic logic [8:0] dut_y(input int k);
      case (k)
         0: dut_y = bus.oY1;  1: dut_y = bus.oY2;  2: dut_y = bus.oY3;  3: dut_y = bus.oY4;
         4: dut_y = bus.oY5;  5: dut_y = bus.oY6;  6: dut_y = bus.oY7;  7: dut_y = bus.oY8;
         8: dut_y = bus.oY9;  9: dut_y = bus.oY10; default: dut_y = '0;
      endcase
   endfunction

   task automatic test_reset();
      clear_inputs();
      iRST_n = 0;
      #1;
      model_reset();
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (dut_x(k) !== 10'd0 || dut_y(k) !== 9'd0) begin
            errors++;
            $display("FAIL reset_bank[%0d]: got x=%0d y=%0d expected 0/0", k, dut_x(k), dut_y(k));
         end
      end
      checks++;
      if (bus.oCommitDone !== 1'b0 || bus.oOverrun !== 1'b0 || bus.oFrameCnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_status: got done=%0b ovr=%0b fcnt=%0d expected 0/0/0",
                  bus.oCommitDone, bus.oOverrun, bus.oFrameCnt);
      end
      #12;
      iRST_n = 1;
      tick();
      checks++;
      if (bus.oWrReady !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %0b expected 1", bus.oWrReady);
      end
   endtask

   task automatic test_basic();
      bit done_seen = 0;
      do_reset();
      bus.iWrValid = 1; bus.iWrIdx = 4'd3; bus.iWrX = 10'd200; bus.iWrY = 9'd150;
      tick();
      clear_inputs(); bus.iCommit = 1;
      tick();
      clear_inputs(); bus.iEndFrame = 1;
      tick();
      clear_inputs();
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (bus.oCommitDone) done_seen = 1;
         checks++;
         if (bus.oX4 !== m_ax[3] || bus.oY4 !== m_ay[3]) begin
            errors++;
            $display("FAIL basic_x4_edge%0d: got %0d/%0d expected %0d/%0d", i, bus.oX4, bus.oY4, m_ax[3], m_ay[3]);
         end
         if (i == 3 || i == 4) begin
            checks++;
            if (bus.oX4 !== (i == 4 ? 10'd200 : 10'd0)) begin
               errors++;
               $display("FAIL basic_visibility_edge%0d: got %0d expected %0d", i, bus.oX4, (i == 4 ? 200 : 0));
            end
         end
         checks++;
         if (bus.oCommitDone !== m_done) begin
            errors++;
            $display("FAIL basic_done_edge%0d: got %0b expected %0b", i, bus.oCommitDone, m_done);
         end
      end
      checks++;
      if (!done_seen || bus.oWrReady !== 1'b1) begin
         errors++;
         $display("FAIL basic_complete: got done_seen=%0b ready=%0b expected 1/1", done_seen, bus.oWrReady);
      end
      for (int k = 0; k < 10; k++) begin
         if (k == 3) continue;
         checks++;
         if (dut_x(k) !== 10'd0 || dut_y(k) !== 9'd0) begin
            errors++;
            $display("FAIL basic_others[%0d]: got %0d/%0d expected 0/0", k, dut_x(k), dut_y(k));
         end
      end
      tick();
      checks++;
      if (bus.oCommitDone !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_width: got %0b expected 0", bus.oCommitDone);
      end
   endtask

   task automatic test_bad_index();
      bit done_seen = 0;
      do_reset();
      bus.iWrValid = 1; bus.iWrIdx = 4'd12; bus.iWrX = 10'd5; bus.iWrY = 9'd5;
      checks++;
      if (bus.oWrReady !== 1'b1) begin
         errors++;
         $display("FAIL badidx_ready: got %0b expected 1", bus.oWrReady);
      end
      tick();
      clear_inputs(); bus.iCommit = 1;
      tick();
      clear_inputs(); bus.iEndFrame = 1;
      tick();
      clear_inputs();
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.oCommitDone) done_seen = 1;
      end
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (dut_x(k) !== 10'd0 || dut_y(k) !== 9'd0) begin
            errors++;
            $display("FAIL badidx_bank[%0d]: got %0d/%0d expected 0/0", k, dut_x(k), dut_y(k));
         end
      end
      checks++;
      if (!done_seen || bus.oWrReady !== 1'b1) begin
         errors++;
         $display("FAIL badidx_done: got done_seen=%0b ready=%0b expected 1/1", done_seen, bus.oWrReady);
      end
   endtask

   task automatic test_overrun();
      do_reset();
      bus.iWrValid = 1; bus.iWrIdx = 4'd5; bus.iWrX = 10'd77; bus.iWrY = 9'd33;
      tick();
      clear_inputs(); bus.iCommit = 1;
      tick();
      clear_inputs();
      bus.iWrValid = 1; bus.iWrIdx = 4'd5; bus.iWrX = 10'd1; bus.iWrY = 9'd1;
      checks++;
      if (bus.oWrReady !== 1'b0) begin
         errors++;
         $display("FAIL overrun_blocked: got ready=%0b expected 0", bus.oWrReady);
      end
      tick();
      clear_inputs(); bus.iCommit = 1;
      tick();
      clear_inputs();
      checks++;
      if (bus.oOverrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_set: got %0b expected 1", bus.oOverrun);
      end
      bus.iEndFrame = 1;
      tick();
      clear_inputs();
      for (int i = 0; i < 11; i++) tick();
      checks++;
      if (bus.oX6 !== 10'd77 || bus.oY6 !== 9'd33) begin
         errors++;
         $display("FAIL overrun_commit_kept: got %0d/%0d expected 77/33", bus.oX6, bus.oY6);
      end
      checks++;
      if (bus.oOverrun !== 1'b1 || bus.oWrReady !== 1'b1) begin
         errors++;
         $display("FAIL overrun_sticky: got ovr=%0b ready=%0b expected 1/1", bus.oOverrun, bus.oWrReady);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      bus.iWrValid = 1; bus.iWrIdx = 4'd0; bus.iWrX = 10'd10; bus.iWrY = 9'd20;
      tick();
      clear_inputs(); bus.iCommit = 1; bus.iEndFrame = 1;
      tick();
      clear_inputs();
      for (int i = 0; i < 12; i++) tick();
      checks++;
      if (bus.oX1 !== 10'd0 || bus.oCommitDone !== 1'b0) begin
         errors++;
         $display("FAIL simul_no_early_copy: got x1=%0d done=%0b expected 0/0", bus.oX1, bus.oCommitDone);
      end
      bus.iEndFrame = 1;
      tick();
      clear_inputs();
      for (int i = 0; i < 10; i++) tick();
      checks++;
      if (bus.oX1 !== 10'd10 || bus.oY1 !== 9'd20 || bus.oCommitDone !== 1'b1) begin
         errors++;
         $display("FAIL simul_late_copy: got %0d/%0d done=%0b expected 10/20 done=1", bus.oX1, bus.oY1, bus.oCommitDone);
      end
      bus.iWrValid = 1; bus.iWrIdx = 4'd1; bus.iWrX = 10'd300; bus.iWrY = 9'd100; bus.iCommit = 1;
      tick();
      clear_inputs(); bus.iEndFrame = 1;
      tick();
      clear_inputs();
      for (int i = 0; i < 10; i++) tick();
      checks++;
      if (bus.oX2 !== 10'd300 || bus.oY2 !== 9'd100) begin
         errors++;
         $display("FAIL simul_write_commit: got %0d/%0d expected 300/100", bus.oX2, bus.oY2);
      end
   endtask

   task automatic test_reset_mid_copy();
      do_reset();
      bus.iWrValid = 1; bus.iWrIdx = 4'd2; bus.iWrX = 10'd55; bus.iWrY = 9'd44;
      tick();
      clear_inputs(); bus.iCommit = 1;
      tick();
      clear_inputs(); bus.iEndFrame = 1;
      tick();
      clear_inputs();
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (bus.oX3 !== 10'd55) begin
         errors++;
         $display("FAIL midcopy_pre: got %0d expected 55", bus.oX3);
      end
      iRST_n = 0;
      #1;
      model_reset();
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (dut_x(k) !== 10'd0 || dut_y(k) !== 9'd0) begin
            errors++;
            $display("FAIL midcopy_cleared[%0d]: got %0d/%0d expected 0/0", k, dut_x(k), dut_y(k));
         end
      end
      #10;
      iRST_n = 1;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if (bus.oCommitDone !== 1'b0 || bus.oWrReady !== 1'b1 || bus.oX3 !== 10'd0) begin
            errors++;
            $display("FAIL midcopy_after%0d: got done=%0b ready=%0b x3=%0d expected 0/1/0",
                     i, bus.oCommitDone, bus.oWrReady, bus.oX3);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         bus.iWrValid  = ($urandom_range(0, 1) == 1);
         bus.iWrIdx    = 4'($urandom_range(0, 11));
         bus.iWrX      = 10'($urandom);
         bus.iWrY      = 9'($urandom);
         bus.iCommit   = ($urandom_range(0, 15) == 0);
         bus.iEndFrame = ($urandom_range(0, 11) == 0);
         tick();
         for (int k = 0; k < 10; k++) begin
            checks++;
            if (dut_x(k) !== m_ax[k] || dut_y(k) !== m_ay[k]) begin
               errors++;
               $display("FAIL rand_bank[%0d]@%0d: got %0d/%0d expected %0d/%0d",
                        k, c, dut_x(k), dut_y(k), m_ax[k], m_ay[k]);
            end
         end
         checks++;
         if (bus.oWrReady !== m_ready() || bus.oCommitDone !== m_done ||
             bus.oOverrun !== m_overrun || bus.oFrameCnt !== m_fcnt) begin
            errors++;
            $display("FAIL rand_status@%0d: got rdy=%0b done=%0b ovr=%0b fcnt=%0d expected %0b/%0b/%0b/%0d",
                     c, bus.oWrReady, bus.oCommitDone, bus.oOverrun, bus.oFrameCnt,
                     m_ready(), m_done, m_overrun, m_fcnt);
         end
      end
      clear_inputs();
   endtask

   task automatic test_frame_counter();
      do_reset();
      bus.iEndFrame = 1;
      for (int i = 0; i < 65537; i++) tick();
      clear_inputs();
      checks++;
      if (bus.oFrameCnt !== 16'd1 || bus.oFrameCnt !== m_fcnt) begin
         errors++;
         $display("FAIL frame_wrap: got %0d expected 1", bus.oFrameCnt);
      end
   endtask

   initial begin
      edge_no = 0;
      test_reset();
      test_basic();
      test_bad_index();
      test_overrun();
      test_simultaneous();
      test_reset_mid_copy();
      test_random();
      test_frame_counter();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ball_position_buffer.md
BALL_POSITION_BUFFER -- requirements
Module: ball_position_buffer

Interface
REQ-001 SHALL have one clock and one reset: iCLK in 1 (sole clock, rising edge); iRST_n in 1 (asynchronous, active-low reset).
REQ-002 SHALL have port iEndFrame  in  1: single-cycle pulse from the display controller's oEndFrame.
REQ-003 SHALL have port iWrValid  in  1: host write request.
REQ-004 SHALL have port oWrReady  out  1: write accepted on any cycle where iWrValid&&oWrReady.
REQ-005 SHALL have port iWrIdx  in  4: ball index, 0..9.
REQ-006 SHALL have port iWrX  in  10: ball centre X.
REQ-007 SHALL have port iWrY  in  9: ball centre Y.
REQ-008 SHALL have port iCommit  in  1: pulse; shadow bank complete, publish at next frame end.
REQ-009 SHALL have ports oX1..oX10  out  10 each: active X, to display controller iX1..iX10.
REQ-010 SHALL have ports oY1..oY10  out  9 each: active Y, to display controller iY1..iY10.
REQ-011 SHALL have port oCommitDone  out  1: one-cycle pulse when the copy completes.
REQ-012 SHALL have port oOverrun  out  1: sticky; iCommit arrived while a commit was outstanding.
REQ-013 SHALL have port oFrameCnt  out  16: count of iEndFrame pulses.

Function
REQ-014 SHALL hold two banks of 10 entries {X[9:0],Y[8:0]}: shadow (host-written) and active (drives oXn/oYn, entry k -> oX(k+1)/oY(k+1)).
REQ-015 Value X=0 or Y=0 SHALL be stored unchanged; it means "ball hidden" downstream.
REQ-016 SHALL implement FSM states IDLE, PENDING, COPY.
REQ-017 oWrReady SHALL be 1 exactly when state==IDLE.
REQ-018 Accepted write with iWrIdx<=9 SHALL update shadow[iWrIdx] at that edge.
REQ-019 Accepted write with iWrIdx>=10 SHALL be consumed and ignored; no state changes.
REQ-020 IDLE: iCommit high at an edge -> PENDING. A write accepted on that same edge SHALL be included in the commit.
REQ-021 iEndFrame high on the same edge that IDLE->PENDING SHALL NOT start the copy; the next iEndFrame SHALL.
REQ-022 PENDING: iEndFrame high at edge T -> COPY with copy index 0.
REQ-023 COPY: each edge SHALL copy shadow[idx] to active[idx] and increment idx. Entry k is visible on outputs after edge T+1+k.
REQ-024 After copying idx 9 (edge T+10), FSM SHALL return to IDLE. oCommitDone SHALL be 1 for exactly the cycle following edge T+10.
REQ-025 iCommit in PENDING or COPY SHALL set oOverrun=1, held until reset. The commit in progress SHALL be unaffected.
REQ-026 Active bank SHALL change only in COPY. Outputs SHALL be registered, with no combinational path from any input.
REQ-027 oFrameCnt SHALL increment on every iEndFrame pulse in any state, wrapping 65535->0.
REQ-028 A full copy takes 10 cycles, which always fits in vertical blanking after oEndFrame. No timeout is required.

Reset
REQ-029 While iRST_n=0 asynchronously: state=IDLE, copy idx=0, both banks all zero, oCommitDone=0, oOverrun=0, oFrameCnt=0.
REQ-030 Reset asserted mid-COPY or mid-PENDING SHALL abort. The active bank reads all zero and no oCommitDone pulse is produced.
REQ-031 oWrReady SHALL read 1 after reset release (IDLE).

Verification
REQ-032 Basic: write idx3 X=200 Y=150, pulse iCommit, pulse iEndFrame at edge T -> oX4=200/oY4=150 after edge T+4; oCommitDone pulses after T+10; other outputs remain 0.
REQ-033 Bad index: write idx12 X=5 Y=5, commit, frame end -> all oXn/oYn remain 0; no hang; oCommitDone pulses.
REQ-034 Blocking and overrun: iCommit then iWrValid during PENDING -> oWrReady=0, shadow unchanged. Second iCommit in PENDING -> oOverrun=1 sticky. First commit still completes on the next iEndFrame.
REQ-035 Simultaneity: iCommit and iEndFrame on the same edge -> outputs unchanged until the following iEndFrame. Write and iCommit on the same edge -> the write is published.
REQ-036 Reset mid-COPY: assert iRST_n=0 at edge T+5 -> all outputs 0 immediately, no oCommitDone, oWrReady=1 after release.
REQ-037 Counter: 65537 iEndFrame pulses from reset -> oFrameCnt=1.
